// File: rtl/btn_pkg.sv
// Shared types and helpers for the button auto-repeat block.
// The state encoding, the acceleration threshold and the
// lowest-index priority encoder live here.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Number of repeats before the fast repeat rate takes over
  localparam logic [3:0] ACCEL_THRESH = 4'd8;

  // Index of the lowest set bit; returns 0 when no bit is set
  function automatic logic [4:0] lsb_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_evt_buf.sv
// One-entry valid/ready event holding register with a sticky
// overflow flag. A push is accepted when the entry is empty or
// being drained in the same cycle; otherwise it is dropped and
// evt_ovf is set. A drop and ovf_clr in the same cycle leave the
// flag set.
module btn_evt_buf #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_code,
  input  logic             push_rpt,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_code,
  output logic             evt_rpt,
  output logic             evt_ovf
);

  logic accept;
  logic drop;

  // Decide whether an incoming event fits into the entry
  always_comb begin
    accept = push & (~evt_valid | evt_ready);
    drop   = push & evt_valid & ~evt_ready;
  end

  // Holding register: load on accept, clear on handshake, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_code  <= {IDX_W{1'b0}};
      evt_rpt   <= 1'b0;
    end else if (accept) begin
      evt_valid <= 1'b1;
      evt_code  <= push_code;
      evt_rpt   <= push_rpt;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new drop takes priority over a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_ovf <= 1'b0;
    end else if (drop) begin
      evt_ovf <= 1'b1;
    end else if (ovf_clr) begin
      evt_ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/btn_autorepeat.sv
// Button auto-repeat engine: turns debounced button levels into a
// press event followed by repeat events after an initial delay and
// then at a fixed rate, tracking a single focus button.
// Optional macro BTN_AUTOREPEAT_ACCEL_EN halves the repeat period
// once ACCEL_THRESH repeats have been emitted for the same hold.
module btn_autorepeat
  import btn_pkg::*;
#(
  parameter int BTN_WIDTH = 5,
  parameter int CNT_W     = 24,
  parameter int DELAY_CYC = 3000000,
  parameter int RATE_CYC  = 600000,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BTN_WIDTH-1:0] btn_lvl,
  output logic                 evt_valid,
  output logic [IDX_W-1:0]     evt_code,
  output logic                 evt_rpt,
  input  logic                 evt_ready,
  output logic                 evt_ovf,
  input  logic                 ovf_clr
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE_CYC - 1);

  logic [BTN_WIDTH-1:0] btn_prev;
  logic [BTN_WIDTH-1:0] rise;
  logic [IDX_W-1:0]     winner;
  logic                 focus_held;
  state_t               state, state_nx;
  logic [IDX_W-1:0]     focus, focus_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [CNT_W-1:0]     rpt_load;
  logic                 emit;
  logic                 emit_rpt;

  // Edge detection, arbitration winner and focus level lookup
  always_comb begin
    rise       = btn_lvl & ~btn_prev;
    winner     = IDX_W'(lsb_index(32'(rise)));
    focus_held = |(btn_lvl & ({{(BTN_WIDTH-1){1'b0}}, 1'b1} << focus));
  end

`ifdef BTN_AUTOREPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'((RATE_CYC >> 1) - 1);

  logic [3:0] rpt_cnt;
  logic       rpt_clear;
  logic       rpt_step;

  // Repeat counter control and reload selection (fast once threshold is reached)
  always_comb begin
    rpt_step  = emit & emit_rpt;
    rpt_clear = (emit & ~emit_rpt) | (state_nx == IDLE);
    if (rpt_cnt >= (ACCEL_THRESH - 4'd1)) begin
      rpt_load = FAST_LOAD;
    end else begin
      rpt_load = RATE_LOAD;
    end
  end

  // Saturating count of repeats emitted during the current hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt <= 4'd0;
    end else if (rpt_clear) begin
      rpt_cnt <= 4'd0;
    end else if (rpt_step && (rpt_cnt < ACCEL_THRESH)) begin
      rpt_cnt <= rpt_cnt + 4'd1;
    end
  end
`else
  // Constant repeat period
  always_comb begin
    rpt_load = RATE_LOAD;
  end
`endif

  // Next-state, counter and event generation
  always_comb begin
    state_nx = state;
    focus_nx = focus;
    cnt_nx   = cnt;
    emit     = 1'b0;
    emit_rpt = 1'b0;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|rise) begin
            emit     = 1'b1;
            focus_nx = winner;
            cnt_nx   = DELAY_LOAD;
            state_nx = DELAY;
          end else begin
            state_nx = IDLE;
          end
        end
        DELAY, REPEAT: begin
          if (|rise) begin
            emit     = 1'b1;
            focus_nx = winner;
            cnt_nx   = DELAY_LOAD;
            state_nx = DELAY;
          end else if (!focus_held) begin
            state_nx = IDLE;
          end else if (cnt == {CNT_W{1'b0}}) begin
            emit     = 1'b1;
            emit_rpt = 1'b1;
            cnt_nx   = rpt_load;
            state_nx = REPEAT;
          end else begin
            cnt_nx = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State, focus, counter and previous-level registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev <= {BTN_WIDTH{1'b0}};
      state    <= IDLE;
      focus    <= {IDX_W{1'b0}};
      cnt      <= {CNT_W{1'b0}};
    end else begin
      btn_prev <= btn_lvl;
      state    <= state_nx;
      focus    <= focus_nx;
      cnt      <= cnt_nx;
    end
  end

  btn_evt_buf #(
    .IDX_W(IDX_W)
  ) u_evt_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (emit),
    .push_code (winner_or_focus(emit_rpt)),
    .push_rpt  (emit_rpt),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_rpt   (evt_rpt),
    .evt_ovf   (evt_ovf)
  );

  // Press events carry the new winner, repeats carry the held focus
  function automatic logic [IDX_W-1:0] winner_or_focus(input logic is_rpt);
    if (is_rpt) begin
      return focus;
    end else begin
      return winner;
    end
  endfunction

endmodule

// File: tb/tb_btn_autorepeat.sv
// Directed testbench for btn_autorepeat (DELAY_CYC=10, RATE_CYC=4).
// Expected events are queued with their expected cycle when stimulus
// is driven; a monitor pops and compares them on each handshake.
module tb_btn_autorepeat;

  localparam int BW = 5;
  localparam int IW = 3;

`ifdef BTN_AUTOREPEAT_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
  localparam int LONG_HOLD = 60;
`else
  localparam bit ACCEL_ON = 1'b0;
  localparam int LONG_HOLD = 40;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic [BW-1:0] btn_lvl;
  logic          evt_valid;
  logic [IW-1:0] evt_code;
  logic          evt_rpt;
  logic          evt_ready;
  logic          evt_ovf;
  logic          ovf_clr;

  typedef struct {
    logic [IW-1:0] code;
    logic          rpt;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  btn_autorepeat #(
    .BTN_WIDTH(BW),
    .CNT_W    (24),
    .DELAY_CYC(10),
    .RATE_CYC (4),
    .IDX_W    (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .btn_lvl  (btn_lvl),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_rpt  (evt_rpt),
    .evt_ready(evt_ready),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge N, cyc == N
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input int code, input bit rpt, input int at);
    exp_t e;
    e.code = IW'(code);
    e.rpt  = rpt;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: compare every accepted event with the queue head
  always @(negedge clk) begin
    #1;
    if (rst === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_evt: observed code=%0d rpt=%0d at cyc %0d, expected none",
               evt_code, evt_rpt, cyc);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_code", 32'(evt_code), 32'(e.code));
        chk("evt_rpt", 32'(evt_rpt), 32'(e.rpt));
        if (e.cyc >= 0) begin
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int t;
    int n;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    en        = 1'b1;
    btn_lvl   = 5'b00000;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    tick(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_rpt", 32'(evt_rpt), 32'd0);
    chk("rst_ovf", 32'(evt_ovf), 32'd0);
    rst = 1'b1;
    tick(2);

    // Press/release: one press event, no repeat
    btn_lvl = 5'b00100;
    t0 = cyc + 1;
    push(2, 1'b0, t0);
    tick(3);
    btn_lvl = 5'b00000;
    tick(15);
    chk("press_release_done", 32'(sb.size()), 32'd0);

    // Hold timing: press then repeats at +10, +14, +18, +22, +26
    btn_lvl = 5'b00010;
    t0 = cyc + 1;
    push(1, 1'b0, t0);
    for (int k = 0; k < 5; k++) push(1, 1'b1, t0 + 10 + 4 * k);
    tick(30);
    btn_lvl = 5'b00000;
    tick(15);
    chk("hold_done", 32'(sb.size()), 32'd0);

    // Simultaneous press (lowest wins), then refocus to button 3
    btn_lvl = 5'b10010;
    t0 = cyc + 1;
    push(1, 1'b0, t0);
    tick(5);
    btn_lvl = 5'b11010;
    t1 = cyc + 1;
    push(3, 1'b0, t1);
    push(3, 1'b1, t1 + 10);
    tick(12);
    btn_lvl = 5'b00000;
    tick(15);
    chk("refocus_done", 32'(sb.size()), 32'd0);

    // Backpressure: entry held, repeat dropped, ovf set / clear / set-wins
    evt_ready = 1'b0;
    btn_lvl = 5'b00001;
    tick(1);
    chk("bp_valid", 32'(evt_valid), 32'd1);
    chk("bp_code", 32'(evt_code), 32'd0);
    chk("bp_ovf0", 32'(evt_ovf), 32'd0);
    tick(9);
    chk("bp_hold_valid", 32'(evt_valid), 32'd1);
    chk("bp_hold_ovf", 32'(evt_ovf), 32'd0);
    tick(1);
    chk("bp_ovf_set", 32'(evt_ovf), 32'd1);
    chk("bp_keep_code", 32'(evt_code), 32'd0);
    chk("bp_keep_rpt", 32'(evt_rpt), 32'd0);
    ovf_clr = 1'b1;
    tick(1);
    chk("bp_ovf_clr", 32'(evt_ovf), 32'd0);
    tick(3);
    chk("bp_set_wins", 32'(evt_ovf), 32'd1);
    ovf_clr = 1'b0;
    btn_lvl = 5'b00000;
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("bp_ovf_clr2", 32'(evt_ovf), 32'd0);
    push(0, 1'b0, -1);
    evt_ready = 1'b1;
    tick(3);
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_valid_low", 32'(evt_valid), 32'd0);

    // Enable gating: held button at en rise gives no event
    en = 1'b0;
    btn_lvl = 5'b10000;
    tick(3);
    chk("en_off_valid", 32'(evt_valid), 32'd0);
    en = 1'b1;
    tick(15);
    chk("en_held_valid", 32'(evt_valid), 32'd0);
    btn_lvl = 5'b00000;
    tick(2);
    btn_lvl = 5'b10000;
    t0 = cyc + 1;
    push(4, 1'b0, t0);
    tick(3);
    btn_lvl = 5'b00000;
    tick(5);
    chk("en_done", 32'(sb.size()), 32'd0);

    // en low keeps a pending entry
    evt_ready = 1'b0;
    btn_lvl = 5'b00100;
    tick(2);
    en = 1'b0;
    tick(3);
    chk("en_keep_valid", 32'(evt_valid), 32'd1);
    chk("en_keep_code", 32'(evt_code), 32'd2);
    btn_lvl = 5'b00000;
    en = 1'b1;
    push(2, 1'b0, -1);
    evt_ready = 1'b1;
    tick(3);
    chk("en_keep_done", 32'(sb.size()), 32'd0);

    // Long hold: constant rate, or fast rate after 8 repeats when accelerated
    btn_lvl = 5'b00010;
    t0 = cyc + 1;
    push(1, 1'b0, t0);
    t = t0 + 10;
    n = 0;
    while (t < t0 + LONG_HOLD) begin
      push(1, 1'b1, t);
      n++;
      t += (ACCEL_ON && n >= 8) ? 2 : 4;
    end
    tick(LONG_HOLD);
    btn_lvl = 5'b00000;
    tick(15);
    chk("long_hold_done", 32'(sb.size()), 32'd0);

    // Reset mid-hold: clears everything, held button re-presses after release
    evt_ready = 1'b0;
    btn_lvl = 5'b01000;
    tick(3);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_ovf", 32'(evt_ovf), 32'd0);
    tick(2);
    rst = 1'b1;
    t0 = cyc + 1;
    push(3, 1'b0, t0);
    evt_ready = 1'b1;
    tick(3);
    btn_lvl = 5'b00000;
    tick(3);
    chk("mid_rst_done", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_autorepeat.md
Name: btn_autorepeat

Overview:
- Consumer of debounced button levels, placed between the debounce stage and game control logic (cursor movement, digit select).
- Turns held buttons into key events: one press event on the rising edge, then repeat events after an initial delay, then at a fixed rate.
- Tracks only one focus button at a time.
- Events leave through a one-entry valid/ready buffer, so the game FSM can stall without losing timing state.

Parameters:
- BTN_WIDTH, 5: number of button lines.
- CNT_W, 24: width of the delay/rate down-counter.
- DELAY_CYC, 3000000: cycles from the press event to the first repeat (0.5 s at 6 MHz). Must be ≥2.
- RATE_CYC, 600000: cycles between repeats (100 ms at 6 MHz). Must be ≥2.
- IDX_W, 3: width of the key code. Must satisfy 2^IDX_W ≥ BTN_WIDTH.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: one clock; reset is asynchronous and active-low.
- en, input, 1: repeat engine enable.
- btn_lvl, input, BTN_WIDTH: debounced button levels, 1 = pressed.
- evt_valid, output, 1: event pending.
- evt_code, output, IDX_W: index of the button that produced the event.
- evt_rpt, output, 1: 0 = initial press, 1 = auto-repeat.
- evt_ready, input, 1: consumer accepts the event.
- evt_ovf, output, 1: sticky flag, an event was dropped.
- ovf_clr, input, 1: clears evt_ovf.

Behaviour:
- Reset values, all zero: btn_prev, state=IDLE, focus, cnt, evt_valid, evt_code, evt_rpt, evt_ovf.
- btn_prev registers btn_lvl every cycle, regardless of en.
- Edge detect: rise = btn_lvl & ~btn_prev.
- Latency: the first cycle btn_lvl is sampled high at an edge, evt_valid is set at that same edge (1 clock from input change).
- Arbitration: when several bits rise in one cycle, the lowest index wins. Other rising bits are ignored for that press.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: any rise → emit (code = winner, rpt = 0); focus ← winner; cnt ← DELAY_CYC-1; go to DELAY.
  - DELAY: priority order is
    1. a rise on any button: refocus, emit rpt=0, reload DELAY_CYC-1, stay in DELAY;
    2. else focus bit low: go to IDLE, no event;
    3. else cnt==0: emit rpt=1, cnt ← RATE_CYC-1, go to REPEAT;
    4. else cnt decrements.
  - REPEAT: same priority order; at cnt==0, emit rpt=1, reload RATE_CYC-1, stay in REPEAT.
  - A release of the focus and a rise of another button in the same cycle: the rise wins (refocus).
  - A rise of the focus button itself cannot occur while it is held.
- Resulting timing: the first repeat is emitted exactly DELAY_CYC cycles after the press event; subsequent repeats are emitted every RATE_CYC cycles.
- en low:
  - FSM forced to IDLE; no new events.
  - The pending buffer entry is kept.
  - Buttons already held when en rises produce no event; only a new rise does.
- Output buffer:
  - evt_valid stays high, with code/rpt stable, until evt_valid & evt_ready.
  - New event and the buffer is empty or being drained this cycle: the entry is loaded (back-to-back at 1 event/cycle is legal).
  - New event, evt_valid=1 and evt_ready=0: the new event is dropped, evt_ovf ← 1, and the FSM still advances (timing is not stalled).
  - ovf_clr: evt_ovf ← 0. If a drop occurs in the same cycle, set wins.
- Reset mid-hold: everything clears. After reset release, buttons held throughout reset produce a press event on the first sampled cycle, because btn_prev resets to 0.

Optional Feature:
- Macro: BTN_AUTOREPEAT_ACCEL_EN.
- When defined:
  - A 4-bit repeat counter increments per repeat, saturating at 8.
  - Once it reaches 8, reloads use (RATE_CYC>>1)-1.
  - The counter clears on refocus, release, or en low.
- When undefined: the rate is constant; no counter logic is present.

Decomposition:
- Package btn_pkg holds:
  - the state enum (IDLE, DELAY, REPEAT);
  - the ACCEL_THRESH=8 constant;
  - the lowest-set-bit priority-encoder function.
- One sub-module, btn_evt_buf: the one-entry valid/ready holding register plus ovf logic.
- The FSM and counter stay in btn_autorepeat.

Test Plan:
- All test runs use DELAY_CYC=10 and RATE_CYC=4.
- Press/release: btn_lvl=5'b00100 held 3 cycles, evt_ready=1 → exactly one event: code=2, rpt=0, 1 cycle after the rise; FSM returns to IDLE with no repeat.
- Hold timing: btn 1 held 30 cycles, ready=1 → press event at t0; repeats at t0+10, +14, +18, +22, +26 (5 repeats, all code=1, rpt=1).
- Simultaneous press and refocus: 5'b10010 rises at once → code=1 only. At cycle 5, btn 3 rises while btn 1 is still held → code=3 rpt=0, delay restarts, first repeat 10 cycles later with code=3.
- Backpressure: hold btn 0 with evt_ready=0 → first event held stable; at the first repeat, evt_ovf=1 and the entry stays code=0 rpt=0. Pulse ovf_clr → evt_ovf=0.
- Enable gating: btn 4 pressed while en=0, then en rises with the button held → no event. Release and press again → event code=4.
- ACCEL (macro defined): hold 60 cycles → repeat gaps of 4 cycles up to and including the 8th repeat, then gaps of 2.
